// File: rtl/pn_gain_mult.sv
// pn_gain_mult: three-stage I/Q gain multiplier with periodic gain reload.
//   stage p0: input register; captures the sample and the gain it will use
//   stage p1: full-precision signed multiply
//   stage p2: floor shift by SHIFT, clamp to 16 bits, clip flag
// The applied gain reloads from Gain every UPD accepted samples unless Freeze is high.
// Optional feature: define PN_GAIN_SATCNT_EN to add the Sat_Cnt / Sat_Clr clip counter.
module pn_gain_mult #(
    parameter int          DW       = 12,
    parameter int          SHIFT    = 10,
    parameter int          UPD      = 256,
    parameter logic [15:0] GAIN_RST = 16'h0400
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [15:0]          Gain,
    input  logic                 Freeze,
    input  logic signed [DW-1:0] In_I,
    input  logic signed [DW-1:0] In_Q,
    input  logic                 In_Valid,
    output logic signed [15:0]   Out_I,
    output logic signed [15:0]   Out_Q,
    output logic                 Out_Valid,
    output logic                 Sat,
`ifdef PN_GAIN_SATCNT_EN
    output logic [15:0]          Sat_Cnt,
    input  logic                 Sat_Clr,
`endif
    output logic [15:0]          Gain_Cur
);

    // Product of a DW-bit signed sample and a zero-extended 16-bit gain.
    localparam int                   PW       = DW + 17;
    localparam logic [15:0]          CNT_LAST = 16'(UPD - 1);
    localparam logic signed [PW-1:0] POS_MAX  = PW'(32767);
    localparam logic signed [PW-1:0] NEG_MIN  = PW'(-32768);

    function automatic logic signed [PW-1:0] shift_floor(input logic signed [PW-1:0] prod);
        return prod >>> SHIFT;
    endfunction

    function automatic logic is_clip(input logic signed [PW-1:0] v);
        return (v > POS_MAX) || (v < NEG_MIN);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [PW-1:0] v);
        if (v > POS_MAX) begin
            return 16'h7FFF;
        end else if (v < NEG_MIN) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    logic [15:0]          r_cnt;
    logic [15:0]          r_gain_cur;
    logic                 r_vld_p0;
    logic                 r_vld_p1;
    logic                 r_vld_p2;
    logic signed [DW-1:0] r_i_p0;
    logic signed [DW-1:0] r_q_p0;
    logic [15:0]          r_gain_p0;
    logic signed [PW-1:0] r_prod_i_p1;
    logic signed [PW-1:0] r_prod_q_p1;
    logic signed [15:0]   r_out_i_p2;
    logic signed [15:0]   r_out_q_p2;
    logic                 r_sat_p2;

    logic signed [PW-1:0] w_gain_ext_p0;
    logic signed [PW-1:0] w_i_ext_p0;
    logic signed [PW-1:0] w_q_ext_p0;
    logic signed [PW-1:0] w_sh_i_p1;
    logic signed [PW-1:0] w_sh_q_p1;
    logic                 w_clip_i_p1;
    logic                 w_clip_q_p1;

    assign w_gain_ext_p0 = PW'($signed({1'b0, r_gain_p0}));
    assign w_i_ext_p0    = PW'(r_i_p0);
    assign w_q_ext_p0    = PW'(r_q_p0);
    assign w_sh_i_p1     = shift_floor(r_prod_i_p1);
    assign w_sh_q_p1     = shift_floor(r_prod_q_p1);
    assign w_clip_i_p1   = is_clip(w_sh_i_p1);
    assign w_clip_q_p1   = is_clip(w_sh_q_p1);

    // Sample counter and gain reload; the reload lands on the edge that accepts the last sample of a period.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt      <= '0;
            r_gain_cur <= GAIN_RST;
        end else if (In_Valid) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                if (!Freeze) begin
                    r_gain_cur <= Gain;
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Valid pipeline; bubbles travel with the data and a reset drops everything in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p0 <= In_Valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // Stage p0: register the sample together with the gain in force before any reload on this edge.
    always_ff @(posedge Clk) begin
        if (In_Valid) begin
            r_i_p0    <= In_I;
            r_q_p0    <= In_Q;
            r_gain_p0 <= r_gain_cur;
        end
    end

    // Stage p1: full-precision product, cannot overflow PW bits.
    always_ff @(posedge Clk) begin
        if (r_vld_p0) begin
            r_prod_i_p1 <= w_i_ext_p0 * w_gain_ext_p0;
            r_prod_q_p1 <= w_q_ext_p0 * w_gain_ext_p0;
        end
    end

    // Stage p2: shift, clamp and flag; data holds across bubbles while the clip flag drops.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_out_i_p2 <= '0;
            r_out_q_p2 <= '0;
            r_sat_p2   <= 1'b0;
        end else begin
            r_sat_p2 <= r_vld_p1 && (w_clip_i_p1 || w_clip_q_p1);
            if (r_vld_p1) begin
                r_out_i_p2 <= sat16(w_sh_i_p1);
                r_out_q_p2 <= sat16(w_sh_q_p1);
            end
        end
    end

`ifdef PN_GAIN_SATCNT_EN
    logic [15:0] r_sat_cnt;

    // Clip event counter, sticks at full scale; a clear request overrides a concurrent clip.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sat_cnt <= '0;
        end else if (Sat_Clr) begin
            r_sat_cnt <= '0;
        end else if (r_sat_p2 && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign Sat_Cnt = r_sat_cnt;
`endif

    assign Out_I     = r_out_i_p2;
    assign Out_Q     = r_out_q_p2;
    assign Out_Valid = r_vld_p2;
    assign Sat       = r_sat_p2;
    assign Gain_Cur  = r_gain_cur;

endmodule

// File: tb/tb_pn_gain_mult.sv
// tb_pn_gain_mult: randomized stimulus against a sample-level reference model,
// plus fixed scenarios with hand-computed expectations.
module tb_pn_gain_mult;

    localparam int          DW       = 12;
    localparam int          SHIFT    = 10;
    localparam int          UPD      = 256;
    localparam logic [15:0] GAIN_RST = 16'h0400;

    logic                 Clk = 1'b0;
    logic                 Rst_n = 1'b1;
    logic [15:0]          Gain;
    logic                 Freeze;
    logic signed [DW-1:0] In_I;
    logic signed [DW-1:0] In_Q;
    logic                 In_Valid;
    logic signed [15:0]   Out_I;
    logic signed [15:0]   Out_Q;
    logic                 Out_Valid;
    logic                 Sat;
    logic [15:0]          Gain_Cur;
`ifdef PN_GAIN_SATCNT_EN
    logic [15:0]          Sat_Cnt;
    logic                 Sat_Clr = 1'b0;
`endif

    always #5 Clk = ~Clk;

    pn_gain_mult #(
        .DW(DW), .SHIFT(SHIFT), .UPD(UPD), .GAIN_RST(GAIN_RST)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Gain(Gain),
        .Freeze(Freeze),
        .In_I(In_I),
        .In_Q(In_Q),
        .In_Valid(In_Valid),
        .Out_I(Out_I),
        .Out_Q(Out_Q),
        .Out_Valid(Out_Valid),
        .Sat(Sat),
`ifdef PN_GAIN_SATCNT_EN
        .Sat_Cnt(Sat_Cnt),
        .Sat_Clr(Sat_Clr),
`endif
        .Gain_Cur(Gain_Cur)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int yi;
        int yq;
        bit s;
    } exp_t;

    exp_t        mq[$];
    int          m_cyc;
    int          m_n;
    logic [15:0] m_gain;
    bit          exp_v;
    int          exp_i;
    int          exp_q;
    bit          exp_s;
`ifdef PN_GAIN_SATCNT_EN
    logic [15:0] m_satcnt;
`endif

    function automatic longint scaled(input int x, input int g);
        longint p;
        p = longint'(x) * longint'(g);
        return p >>> SHIFT;
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        exp_t   e;
        longint si;
        longint sq;
        if (!Rst_n) begin
            mq.delete();
            m_cyc  = 0;
            m_n    = 0;
            m_gain = GAIN_RST;
            exp_v  = 1'b0;
            exp_i  = 0;
            exp_q  = 0;
            exp_s  = 1'b0;
`ifdef PN_GAIN_SATCNT_EN
            m_satcnt = 16'd0;
`endif
        end else begin
`ifdef PN_GAIN_SATCNT_EN
            if (Sat_Clr) m_satcnt = 16'd0;
            else if (exp_s && m_satcnt != 16'hFFFF) m_satcnt = m_satcnt + 16'd1;
`endif
            m_cyc = m_cyc + 1;
            exp_v = 1'b0;
            exp_s = 1'b0;
            if (mq.size() > 0 && mq[0].due == m_cyc) begin
                e     = mq.pop_front();
                exp_v = 1'b1;
                exp_i = e.yi;
                exp_q = e.yq;
                exp_s = e.s;
            end
            if (In_Valid) begin
                si    = scaled(int'(In_I), int'(m_gain));
                sq    = scaled(int'(In_Q), int'(m_gain));
                e.due = m_cyc + 2;
                e.yi  = clamp16(si);
                e.yq  = clamp16(sq);
                e.s   = (longint'(e.yi) != si) || (longint'(e.yq) != sq);
                mq.push_back(e);
                if ((m_n % UPD) == UPD - 1 && !Freeze) m_gain = Gain;
                m_n = m_n + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;
    int acc      = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_cycle();
        chk("cyc_out_valid", Out_Valid, exp_v);
        chk("cyc_sat", Sat, exp_s);
        chk("cyc_out_i", Out_I, exp_i);
        chk("cyc_out_q", Out_Q, exp_q);
        chk("cyc_gain_cur", Gain_Cur, m_gain);
`ifdef PN_GAIN_SATCNT_EN
        chk("cyc_sat_cnt", Sat_Cnt, m_satcnt);
`endif
    endtask

    // Drive one cycle of input, compare at the falling edge, return just after the rising edge.
    task automatic step(input bit v, input int xi, input int xq);
        In_Valid = v;
        In_I     = DW'(xi);
        In_Q     = DW'(xq);
        @(negedge Clk);
        check_cycle();
        @(posedge Clk);
        #1;
        if (v) acc = acc + 1;
    endtask

    task automatic do_reset();
        In_Valid = 1'b0;
        Rst_n    = 1'b0;
        #1;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_sat", Sat, 0);
        chk("rst_out_i", Out_I, 0);
        chk("rst_gain_cur", Gain_Cur, 16'h0400);
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        acc   = 0;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial begin
        bit pat[5];
        bit v;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        Gain     = 16'h0400;
        Freeze   = 1'b0;
        In_Valid = 1'b0;
        In_I     = '0;
        In_Q     = '0;
        #2;
        do_reset();
        chk("rst_out_q", Out_Q, 0);

        // Valid pattern 1,0,1,1,0 reappears three cycles later.
        for (int i = 0; i < 7; i++) begin
            step((i < 5) ? pat[i] : 1'b0, 7, -7);
            if (i >= 2) chk("vld_pattern", Out_Valid, pat[i - 2]);
        end

        // Unity gain passthrough, then reset with samples in flight.
        do_reset();
        Gain = 16'h0800;
        repeat (3) step(1'b1, 100, -100);
        chk("unity_valid", Out_Valid, 1);
        chk("unity_out_i", Out_I, 100);
        chk("unity_out_q", Out_Q, -100);
        chk("unity_gain_cur", Gain_Cur, 16'h0400);
        step(1'b1, 100, -100);
        do_reset();

        // Reload after 256 samples doubles the output from sample 257.
        Gain = 16'h0800;
        for (int k = 1; k <= 259; k++) begin
            step(1'b1, 1000, 1000);
            if (k == 256) chk("reload_gain_cur", Gain_Cur, 16'h0800);
            if (k == 258) chk("reload_old_gain", Out_I, 1000);
            if (k == 259) chk("reload_new_gain", Out_I, 2000);
        end

        // Random traffic up to the next wrap, which loads 0x7FFF; other Gain values must not stick.
        while (acc < 512) begin
            Gain   = ((acc % UPD) == UPD - 1) ? 16'h7FFF : 16'($urandom);
            Freeze = ((acc % UPD) == UPD - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample());
        end
        chk("big_gain_cur", Gain_Cur, 16'h7FFF);
        Gain = 16'h1234;
        repeat (3) step(1'b1, 2047, -2048);
        chk("clip_out_i", Out_I, 32767);
        chk("clip_out_q", Out_Q, -32768);
        chk("clip_sat", Sat, 1);

        // Fully random traffic, gains and freezes.
        repeat (200) begin
            Gain   = 16'($urandom);
            Freeze = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample());
        end

        // Freeze skips the first wrap only; second wrap loads 0x0200.
        do_reset();
        repeat (3) step(1'b1, -3, 5);
        chk("neg_out_i", Out_I, -3);
        chk("neg_out_q", Out_Q, 5);
        chk("neg_sat", Sat, 0);
        while (acc < 520) begin
            Gain   = ((acc % UPD) == UPD - 1) ? 16'h0200 : 16'($urandom);
            Freeze = (acc == 255) ? 1'b1 : (acc == 511) ? 1'b0 : 1'($urandom_range(0, 1));
            v      = ($urandom_range(0, 4) != 0);
            step(v, rnd_sample(), rnd_sample());
            if (v && acc == 256) chk("frozen_gain_cur", Gain_Cur, 16'h0400);
            if (v && acc == 512) chk("thawed_gain_cur", Gain_Cur, 16'h0200);
        end
        Freeze = 1'b0;
        repeat (3) step(1'b0, 0, 0);

`ifdef PN_GAIN_SATCNT_EN
        do_reset();
        chk("satcnt_rst", Sat_Cnt, 0);
        Gain = 16'hFFFF;
        repeat (256) step(1'b1, 0, 0);
        chk("satcnt_gain_cur", Gain_Cur, 16'hFFFF);
        repeat (5) step(1'b1, 2047, 0);
        repeat (3) step(1'b0, 0, 0);
        chk("satcnt_five", Sat_Cnt, 5);
        step(1'b1, 2047, 0);
        repeat (2) step(1'b0, 0, 0);
        chk("satcnt_sat_before_clr", Sat, 1);
        Sat_Clr = 1'b1;
        step(1'b0, 0, 0);
        Sat_Clr = 1'b0;
        chk("satcnt_clr_wins", Sat_Cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pn_gain_mult.md
PN_GAIN_MULT -- requirements
Module: pn_gain_mult

Interface
REQ-001 SHALL have parameter DW, default 12: signed I/Q input sample width.
REQ-002 SHALL have parameter SHIFT, default 10: arithmetic right shift applied to the product; gain 2^SHIFT = unity.
REQ-003 SHALL have parameter UPD, default 256: number of accepted samples between gain reloads (2..65535).
REQ-004 SHALL have parameter GAIN_RST, default 16'h0400: gain register reset value.
REQ-005 SHALL have port Clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port Rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port Gain, input, 16: unsigned gain word from the AGC stage (its Dout).
REQ-008 SHALL have port Freeze, input, 1: while high, gain reloads are suppressed.
REQ-009 SHALL have ports In_I and In_Q, input, DW each: signed two's-complement samples.
REQ-010 SHALL have port In_Valid, input, 1: sample qualifier; no backpressure.
REQ-011 SHALL have ports Out_I and Out_Q, output, 16 each: signed scaled samples.
REQ-012 SHALL have port Out_Valid, output, 1: output qualifier.
REQ-013 SHALL have port Sat, output, 1: clip flag, aligned with Out_Valid.
REQ-014 SHALL have port Gain_Cur, output, 16: gain register value currently applied.

Function
REQ-015 SHALL compute per channel y = sat16((x * Gain_Cur) >>> SHIFT), x signed DW-bit, Gain_Cur unsigned zero-extended, full-precision (DW+17)-bit signed product, floor rounding.
REQ-016 sat16 SHALL clamp to +32767 / -32768; Sat=1 on a valid output if either channel clamped, else 0.
REQ-017 Pipeline SHALL be 3 stages (input register, multiply, shift/saturate): Out_Valid equals In_Valid delayed exactly 3 cycles, data aligned.
REQ-018 Outputs SHALL hold their last value while Out_Valid=0; Sat SHALL be 0 when Out_Valid=0.
REQ-019 Sample counter SHALL increment on each In_Valid=1 cycle, wrapping from UPD-1 to 0.
REQ-020 On a cycle with In_Valid=1, counter=UPD-1 and Freeze=0, Gain_Cur SHALL load Gain at that edge; the sample accepted in that cycle uses the old gain, the next accepted sample the new gain.
REQ-021 Freeze=1 at the wrap cycle SHALL skip that reload only; counter still wraps; the next reload occurs UPD samples later.
REQ-022 Gain changes between reload points SHALL have no effect.
REQ-023 Gain applied to a sample SHALL be captured in stage 1 with that sample, so a reload never corrupts samples in flight.
REQ-024 Gaps in In_Valid SHALL not advance the counter or pipeline meaning; bubbles propagate as Out_Valid=0.

Reset
REQ-025 Rst_n low SHALL asynchronously clear Out_I, Out_Q, Out_Valid, Sat, all pipeline valids, the sample counter, and set Gain_Cur=GAIN_RST.
REQ-026 Reset mid-stream SHALL discard in-flight samples; first Out_Valid after release occurs 3 cycles after the first post-reset In_Valid.

Configuration
REQ-027 With macro PN_GAIN_SATCNT_EN defined, SHALL add output Sat_Cnt (16-bit) and input Sat_Clr (1-bit): Sat_Cnt increments on each Sat=1 cycle, saturates at 16'hFFFF, Sat_Clr=1 clears it synchronously (clear wins over increment), reset value 0.
REQ-028 Without PN_GAIN_SATCNT_EN, Sat_Cnt and Sat_Clr SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset, continuous In_Valid, In_I=100, In_Q=-100 -> after 3 cycles Out_I=100, Out_Q=-100, Out_Valid=1, Gain_Cur=0x0400.
REQ-030 Gain=0x0800, 256 samples In_I=1000 -> samples 1..256 give 1000; sample 257 onward gives 2000; Gain_Cur=0x0800.
REQ-031 Gain_Cur=0x7FFF, In_I=2047, In_Q=-2048 -> Out_I=32767, Out_Q=-32768, Sat=1; In_I=-3, gain 0x0400 -> Out_I=-3, Sat=0.
REQ-032 Gain=0x0200 with Freeze=1 during first wrap -> Gain_Cur stays 0x0400; Freeze=0 at second wrap -> loads 0x0200 after sample 512.
REQ-033 In_Valid pattern 1,0,1,1,0 -> Out_Valid 1,0,1,1,0 delayed 3 cycles; Rst_n pulse mid-stream -> Out_Valid low immediately, counter 0.
REQ-034 With PN_GAIN_SATCNT_EN, 5 saturating samples -> Sat_Cnt=5; Sat_Clr with concurrent Sat -> Sat_Cnt=0.
